oai31_bist_ctrl: RTL and testbench

OAI31_BIST_CTRL -- requirements
Module: oai31_bist_ctrl

---
 rtl/oai31_bist_ctrl_pkg.sv | 23 ++
 rtl/oai31_bist_ctrl.sv | 132 +++++++++++++
 tb/tb_oai31_bist_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/oai31_bist_ctrl_pkg.sv
// Shared definitions for the oai31 BIST controller.
//   state_t    : controller FSM states
//   VEC_W      : stimulus vector width {A1,A2,A3,B}
//   CNT_W      : settle counter width
//   oai31_exp  : golden response of an oai31 cell for a given vector
package oai31_bist_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int VEC_W = 4;
  localparam int CNT_W = 4;

  // v = {A1,A2,A3,B}; ZN = ~((A1|A2|A3) & B)
  function automatic logic oai31_exp(input logic [VEC_W-1:0] v);
    return ~((v[3] | v[2] | v[1]) & v[0]);
  endfunction

endpackage

// File: rtl/oai31_bist_ctrl.sv
// BIST controller for a single oai31 standard cell.
// Walks all 16 input vectors in ascending order, holds each for
// SETTLE_CYCLES cycles, then compares the cell output against the
// golden oai31 function in one CHECK cycle.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   START, ABORT        : launch a pass (IDLE only) / kill a running pass
//   ZN_IN               : cell-under-test output
//   A1, A2, A3, B       : registered stimulus to the cell
//   BUSY, DONE, PASS    : pass in progress / completion pulse / clean result
//   ERR_CNT             : mismatch count, saturating at 15
//   FAIL_VLD, FAIL_VEC  : first failing vector capture
module oai31_bist_ctrl
  import oai31_bist_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN_IN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [3:0]       ERR_CNT,
  output logic             FAIL_VLD,
  output logic [VEC_W-1:0] FAIL_VEC
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] stim_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       err_q;
  logic             fvld_q;
  logic [VEC_W-1:0] fvec_q;

  // Compare result for the vector currently on the cell pins
  logic       mismatch;
  logic [3:0] err_d;

  always_comb begin
    mismatch = (ZN_IN != oai31_exp(stim_q));
    err_d    = err_q;
    if (mismatch && err_q != 4'd15) err_d = err_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
    end else if (ABORT) begin
      // Abort wins everywhere; result registers are deliberately kept so
      // the partial outcome can still be read back.
      state_q <= ST_IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != ST_IDLE) pass_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_SETTLE;
            vec_q   <= '0;
            stim_q  <= '0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fvld_q) begin
            fvld_q <= 1'b1;
            fvec_q <= vec_q;
          end
          if (vec_q != 4'hF) begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_q + 4'd1;
            stim_q  <= vec_q + 4'd1;
            cnt_q   <= CNT_LOAD;
          end else begin
            // Result is decided here so PASS includes the final compare
            state_q <= ST_FINISH;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign {A1, A2, A3, B} = stim_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fvld_q;
  assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_oai31_bist_ctrl.sv
// Self-checking bench for oai31_bist_ctrl with a behavioural oai31 cell.
module gf180mcu_fd_sc_mcu7t5v0__oai31_1 (
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B,
  output logic ZN
);
  assign ZN = ~((A1 | A2 | A3) & B);
endmodule

module tb_oai31_bist_ctrl;
  localparam int S = 2;
  localparam int N = 16 * (S + 1);

  logic CLK = 1'b0;
  logic RST, START, ABORT, ZN_IN, zn_cell;
  logic A1, A2, A3, B, BUSY, DONE, PASS, FAIL_VLD;
  logic [3:0] ERR_CNT, FAIL_VEC;
  int mode;  // 0 good cell, 1 tie-1, 2 tie-0, 3 inverted cell

  int n_vec = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  oai31_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN_IN(ZN_IN),
    .A1(A1), .A2(A2), .A3(A3), .B(B), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_CNT(ERR_CNT), .FAIL_VLD(FAIL_VLD), .FAIL_VEC(FAIL_VEC)
  );

  gf180mcu_fd_sc_mcu7t5v0__oai31_1 cut (
    .A1(A1), .A2(A2), .A3(A3), .B(B), .ZN(zn_cell)
  );

  assign ZN_IN = (mode == 0) ? zn_cell : (mode == 1) ? 1'b1 :
                 (mode == 2) ? 1'b0 : ~zn_cell;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pass timeline: cycle t counts from START acceptance; vector index is
  // t/(S+1), the last cycle of each vector is its compare, t==N is FINISH.
  bit valid = 0, active = 0;
  int t = 0;
  bit m_busy, m_done, m_pass, m_fvld;
  int m_err, m_fvec, m_stim;

  function automatic bit golden(input int v);
    return !((v % 2 == 1) && (v >= 2));
  endfunction

  function automatic bit cell_out(input int v);
    case (mode)
      0: return golden(v);
      1: return 1'b1;
      2: return 1'b0;
      default: return !golden(v);
    endcase
  endfunction

  always @(negedge CLK) begin
    if (valid)
      chk("cycle",
          {16'd0, m_busy, m_done, m_pass, m_fvld, 4'(m_err), 4'(m_fvec), 4'(m_stim)},
          {16'd0, BUSY, DONE, PASS, FAIL_VLD, ERR_CNT, FAIL_VEC, A1, A2, A3, B});
    // advance model to the state after the coming rising edge
    if (RST) begin
      valid = 1; active = 0; m_busy = 0; m_done = 0; m_pass = 0;
      m_err = 0; m_fvld = 0; m_fvec = 0; m_stim = 0;
    end else if (active) begin
      if (ABORT) begin
        active = 0; m_busy = 0; m_done = 0; m_pass = 0; m_stim = 0;
      end else if (t < N) begin
        if (t % (S + 1) == S && cell_out(t / (S + 1)) != golden(t / (S + 1))) begin
          if (m_err < 15) m_err++;
          if (!m_fvld) begin m_fvld = 1; m_fvec = t / (S + 1); end
        end
        t++;
        if (t == N) begin
          m_done = 1; m_busy = 0; m_stim = 0; m_pass = (m_err == 0);
        end else m_stim = t / (S + 1);
      end else begin
        m_done = 0; active = 0;
      end
    end else if (START && !ABORT) begin
      active = 1; t = 0; m_busy = 1; m_stim = 0; m_pass = 0;
      m_err = 0; m_fvld = 0; m_fvec = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Runs one pass; optionally re-pulses START at busy cycle k (should be ignored)
  task automatic run_pass(input int k, output int n);
    n = 0;
    START = 1; step(); START = 0;
    while (BUSY && n < 200) begin
      n++;
      START = (n == k);
      step();
    end
    START = 0;
  endtask

  int n, dones;

  initial begin
    mode = 0; RST = 1; START = 0; ABORT = 0;
    repeat (3) step();
    RST = 0; step();
    chk("reset_state", {BUSY, DONE, PASS, FAIL_VLD, ERR_CNT, FAIL_VEC, A1, A2, A3, B}, 0);

    // good cell
    run_pass(-1, n);
    chk("good_busy_cycles", n, 48);
    chk("good_done", DONE, 1);
    chk("good_pass", PASS, 1);
    chk("good_err", ERR_CNT, 0);
    chk("good_fvld", FAIL_VLD, 0);
    step();
    chk("done_one_cycle", DONE, 0);
    chk("pass_held_idle", PASS, 1);

    // ZN stuck at 1: vectors 3,5,...,15 fail
    mode = 1; run_pass(-1, n); step();
    chk("tie1_err", ERR_CNT, 7);
    chk("tie1_fvec", FAIL_VEC, 4'b0011);
    chk("tie1_pass", PASS, 0);
    chk("tie1_fvld", FAIL_VLD, 1);

    // ZN stuck at 0: the 9 vectors expecting 1 fail
    mode = 2; run_pass(-1, n); step();
    chk("tie0_err", ERR_CNT, 9);
    chk("tie0_fvec", FAIL_VEC, 4'b0000);

    // inverted cell: 16 mismatches, counter saturates
    mode = 3; run_pass(-1, n); step();
    chk("sat_err", ERR_CNT, 15);
    chk("sat_pass", PASS, 0);

    // START held: back-to-back passes
    mode = 0; dones = 0; START = 1;
    for (int i = 0; i < 120; i++) begin
      if (i == 60) START = 0;
      step();
      if (DONE) dones++;
    end
    START = 0;
    chk("held_start_dones", dones, 2);

    // abort during CHECK of vector 6 (cycle 20) with tie-1 cell
    mode = 1;
    START = 1; step(); START = 0;
    repeat (20) step();
    ABORT = 1; step(); ABORT = 0;
    chk("abort_busy", BUSY, 0);
    chk("abort_stim", {A1, A2, A3, B}, 0);
    chk("abort_err_held", ERR_CNT, 2);
    chk("abort_fvec_held", FAIL_VEC, 4'b0011);
    dones = 0;
    for (int i = 0; i < 5; i++) begin step(); if (DONE) dones++; end
    chk("abort_no_done", dones, 0);
    mode = 0; run_pass(-1, n);
    chk("post_abort_cycles", n, 48);
    chk("post_abort_pass", PASS, 1);
    step();

    // START while busy is ignored
    run_pass(10, n);
    chk("busy_start_cycles", n, 48);
    step();

    // ABORT + START together in IDLE
    ABORT = 1; START = 1; step(); ABORT = 0; START = 0;
    chk("abort_start_idle", BUSY, 0);

    // reset mid-SETTLE after some errors, with an ignored START
    mode = 3;
    START = 1; step(); START = 0;
    repeat (3) step();
    START = 1; step(); START = 0;
    repeat (2) step();
    RST = 1; ABORT = 1; step(); RST = 0; ABORT = 0;
    chk("midpass_reset", {BUSY, DONE, PASS, FAIL_VLD, ERR_CNT, FAIL_VEC, A1, A2, A3, B}, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
